// File: rtl/fc_argmax_classifier.sv
// Argmax stage after the last FC layer: captures class scores and biases, adds them
// with saturation, scans one class per cycle and hands the winner over valid/ack.
module fc_argmax_classifier #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              fc_valid,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] fc_data,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] fc_bias,
  output logic                              end_to_previous,
  output logic                              busy,
  output logic                              result_valid,
  input  logic                              result_ack,
  output logic [IDX_WIDTH-1:0]              class_index,
  output logic [DATA_WIDTH-1:0]             class_score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic [DATA_WIDTH-1:0] data_q [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] bias_q [NUM_CLASSES];

  logic                  capture;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DATA_WIDTH-1:0] cur_bias;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] score;

  // Capture registers only load in IDLE, so upstream is free once end_to_previous pulses.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_capture
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_q[gi] <= '0;
          bias_q[gi] <= '0;
        end else if (capture) begin
          data_q[gi] <= fc_data[gi*DATA_WIDTH +: DATA_WIDTH];
          bias_q[gi] <= fc_bias[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

  // One shared saturating adder, muxed by the scan counter.
  always_comb begin
    cur_data = data_q[cnt_q];
    cur_bias = bias_q[cnt_q];
    sum_wide = {cur_data[DATA_WIDTH-1], cur_data} + {cur_bias[DATA_WIDTH-1], cur_bias};
    if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      score = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      score = sum_wide[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by reset so the pulse stays low while reset is held.
        if (fc_valid && reset) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compare: ties keep the earlier (lower) class index.
        if ((cnt_q == '0) || ($signed(score) > $signed(best_score_q))) begin
          best_score_d = score;
          best_idx_d   = cnt_q;
        end
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    end_to_previous = capture;
    busy            = (state_q != S_IDLE);
    result_valid    = (state_q == S_DONE);
    class_index     = (state_q == S_DONE) ? best_idx_q   : '0;
    class_score     = (state_q == S_DONE) ? best_score_q : '0;
  end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench for fc_argmax_classifier: vector table for scoring/saturation/ties,
// plus hand sequences for handshake corner cases and mid-scan reset.
module tb_fc_argmax_classifier;

  localparam int DW  = 32;
  localparam int NC  = 10;
  localparam int IW  = $clog2(NC);
  localparam int NV  = 8;

  logic               clk;
  logic               reset;
  logic               fc_valid;
  logic [NC*DW-1:0]   fc_data;
  logic [NC*DW-1:0]   fc_bias;
  logic               end_to_previous;
  logic               busy;
  logic               result_valid;
  logic               result_ack;
  logic [IW-1:0]      class_index;
  logic [DW-1:0]      class_score;

  fc_argmax_classifier #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
    .clk             (clk),
    .reset           (reset),
    .fc_valid        (fc_valid),
    .fc_data         (fc_data),
    .fc_bias         (fc_bias),
    .end_to_previous (end_to_previous),
    .busy            (busy),
    .result_valid    (result_valid),
    .result_ack      (result_ack),
    .class_index     (class_index),
    .class_score     (class_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NC*DW-1:0] data;
    logic [NC*DW-1:0] bias;
    logic [IW-1:0]    exp_idx;
    logic [DW-1:0]    exp_score;
  } vec_t;

  vec_t             vecs [NV];
  logic [NC*DW-1:0] tmp_d;
  logic [NC*DW-1:0] tmp_b;
  int               n_checks;
  int               n_fail;
  int               cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int v, input logic [IW-1:0] idx, input logic [DW-1:0] sc);
    vecs[v].data      = tmp_d;
    vecs[v].bias      = tmp_b;
    vecs[v].exp_idx   = idx;
    vecs[v].exp_score = sc;
  endtask

  // Drives one capture cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic start(input int v);
    @(negedge clk);
    fc_data  = vecs[v].data;
    fc_bias  = vecs[v].bias;
    fc_valid = 1'b1;
    #1 check("e2p_on_capture", end_to_previous, 1);
    @(negedge clk);
    fc_valid = 1'b0;
    #1 check("e2p_single_pulse", end_to_previous, 0);
  endtask

  task automatic wait_done(input int start_cyc, output int c);
    c = start_cyc;
    while (!result_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!result_valid) check("result_timeout", 0, 1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    #1;
    check("rv_after_ack", result_valid, 0);
    check("busy_after_ack", busy, 0);
  endtask

  task automatic run_vec(input int v);
    int c;
    start(v);
    wait_done(1, c);
    check("latency", c, 11);
    check("class_index", class_index, vecs[v].exp_idx);
    check("class_score", class_score, vecs[v].exp_score);
    check("busy_in_done", busy, 1);
    $display("vector %0d: latency %0d index %0d score %08h", v, c, class_index, class_score);
    do_ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    fc_valid   = 1'b0;
    result_ack = 1'b0;
    fc_data    = '0;
    fc_bias    = '0;

    // 0: ascending, last class wins
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = DW'(k*10); tmp_b[k*DW +: DW] = '0; end
    set_vec(0, 4'd9, 32'd90);
    // 1: bias breaks equality
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = 32'd5; tmp_b[k*DW +: DW] = '0; end
    tmp_b[3*DW +: DW] = 32'd1;
    set_vec(1, 4'd3, 32'd6);
    // 2: all equal, lowest index kept
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = 32'd7; tmp_b[k*DW +: DW] = '0; end
    set_vec(2, 4'd0, 32'd7);
    // 3: positive saturation
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = '0; tmp_b[k*DW +: DW] = '0; end
    tmp_d[2*DW +: DW] = 32'h7FFF_FFF0;
    tmp_b[2*DW +: DW] = 32'h0000_0100;
    set_vec(3, 4'd2, 32'h7FFF_FFFF);
    // 4: negative saturation everywhere
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = 32'h8000_0000; tmp_b[k*DW +: DW] = 32'hFFFF_FFFF; end
    set_vec(4, 4'd0, 32'h8000_0000);
    // 5: all negative scores
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = DW'(-100 + k); tmp_b[k*DW +: DW] = '0; end
    tmp_d[6*DW +: DW] = DW'(-3);
    set_vec(5, 4'd6, 32'hFFFF_FFFD);
    // 6: huge bias saturates and wins
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = 32'd100; tmp_b[k*DW +: DW] = '0; end
    tmp_b[8*DW +: DW] = 32'h7FFF_FFFF;
    set_vec(6, 4'd8, 32'h7FFF_FFFF);
    // 7: two classes saturate to the same max, lower one kept
    for (int k = 0; k < NC; k++) begin tmp_d[k*DW +: DW] = '0; tmp_b[k*DW +: DW] = '0; end
    tmp_d[1*DW +: DW] = 32'h7FFF_FFFF; tmp_b[1*DW +: DW] = 32'd1;
    tmp_d[4*DW +: DW] = 32'h7FFF_FFFF; tmp_b[4*DW +: DW] = 32'd5;
    set_vec(7, 4'd1, 32'h7FFF_FFFF);

    #3;
    check("reset_busy", busy, 0);
    check("reset_rv", result_valid, 0);
    check("reset_e2p", end_to_previous, 0);
    check("reset_idx", class_index, 0);
    check("reset_score", class_score, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < NV; v++) run_vec(v);

    // fc_valid re-pulsed during SCAN with different data
    start(0);
    repeat (2) @(negedge clk);
    fc_valid = 1'b1;
    fc_data  = vecs[1].data;
    fc_bias  = vecs[1].bias;
    for (int c = 0; c < 3; c++) begin
      #1 check("repulse_no_e2p", end_to_previous, 0);
      @(negedge clk);
    end
    fc_valid = 1'b0;
    wait_done(6, cyc);
    check("repulse_latency", cyc, 11);
    check("repulse_idx", class_index, 9);
    check("repulse_score", class_score, 90);
    $display("repulse: index %0d score %0d", class_index, class_score);

    // ack withheld 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_rv", result_valid, 1);
      check("hold_idx", class_index, 9);
      check("hold_score", class_score, 90);
    end
    $display("hold: result stable for 20 cycles without ack");

    // ack and fc_valid in the same DONE cycle
    @(negedge clk);
    result_ack = 1'b1;
    fc_valid   = 1'b1;
    fc_data    = vecs[1].data;
    fc_bias    = vecs[1].bias;
    #1 check("ackvalid_no_e2p_in_done", end_to_previous, 0);
    @(negedge clk);
    result_ack = 1'b0;
    #1;
    check("ackvalid_e2p_next", end_to_previous, 1);
    check("ackvalid_rv_low", result_valid, 0);
    @(negedge clk);
    fc_valid = 1'b0;
    #1 check("ackvalid_busy", busy, 1);
    wait_done(1, cyc);
    check("ackvalid_latency", cyc, 11);
    check("ackvalid_idx", class_index, 3);
    check("ackvalid_score", class_score, 6);
    $display("ack+valid: index %0d score %0d", class_index, class_score);
    do_ack();

    // reset asserted mid-scan at cnt=4
    start(0);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_rv", result_valid, 0);
    check("midreset_idx", class_index, 0);
    check("midreset_score", class_score, 0);
    check("midreset_e2p", end_to_previous, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_result", result_valid, 0);
    $display("mid-scan reset: operation aborted");
    run_vec(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
